vga_timing_gen: RTL and testbench

Pixel-timing generator for the 640x480 @ 60 Hz display path. It divides the system clock down to the pixel rate and runs the horizontal and vertical counters. It drives active-low sync pulses and the pixel coordinates. It also emits a once-per-frame tick at the start of vertical blank. All drawing, collision and animation logic in the game consumes its `x`, `y`, `video_on` and `p_tick`; `frame_tick` replaces ad-hoc `y==480 && x==0` decoding.

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle driven by vga_timing_gen and consumed by the drawing logic.
// The rgb test-pattern signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb;
`endif

  modport master (
    output p_tick, x, y, hsync, vsync, video_on,
`ifdef VGA_TEST_PATTERN_EN
    output rgb,
`endif
    output frame_tick
  );

  modport slave (
    input p_tick, x, y, hsync, vsync, video_on,
`ifdef VGA_TEST_PATTERN_EN
    input rgb,
`endif
    input frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator: clock divider, x/y counters, sync and blank decodes.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             p_tick;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_nxt, y_nxt;
  logic             hsync_q, vsync_q, video_q;
  logic             hsync_nxt, vsync_nxt, video_nxt;

  assign p_tick = (div == DIV_LAST);

  // x_nxt/y_nxt describe the pixel that follows the current one; registers load them on p_tick
  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = 10'd0;
      y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
  end

  always_comb begin
    hsync_nxt = !((x_nxt >= HS_START) && (x_nxt < HS_END));
    vsync_nxt = !((y_nxt >= VS_START) && (y_nxt < VS_END));
    video_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else begin
      div <= p_tick ? '0 : div + DIV_ONE;
    end
  end

  // Reset values match the decode of pixel (0,0) so outputs stay consistent
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b1;
    end else if (p_tick) begin
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      hsync_q <= hsync_nxt;
      vsync_q <= vsync_nxt;
      video_q <= video_nxt;
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_q;
  assign vga.frame_tick = p_tick && (x_q == 10'd0) && (y_q == V_VIS);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

  logic [11:0] rgb_q, rgb_nxt;

  always_comb begin
    rgb_nxt = 12'h000;
    if (video_nxt) begin
      case (x_nxt / BAR_W)
        10'd0:   rgb_nxt = 12'hfff;
        10'd1:   rgb_nxt = 12'hff0;
        10'd2:   rgb_nxt = 12'h0ff;
        10'd3:   rgb_nxt = 12'h0f0;
        10'd4:   rgb_nxt = 12'hf0f;
        10'd5:   rgb_nxt = 12'hf00;
        10'd6:   rgb_nxt = 12'h00f;
        default: rgb_nxt = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 12'h000;
    end else if (p_tick) begin
      rgb_q <= rgb_nxt;
    end
  end

  assign vga.rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances (default, CLK_DIV=2, small geometry)
// compared every clock against an arithmetic pixel-index model.
module tb_vga_timing_gen;

  localparam int SD  = 2;
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVV = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int FRAME_S = SHT * SVT * SD;

  typedef struct packed {
    logic        p_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_tick;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_full, rst_d2, rst_small;
  always #5 clk = ~clk;

  vga_timing_gen_if bus_full ();
  vga_timing_gen_if bus_d2 ();
  vga_timing_gen_if bus_small ();

  vga_timing_gen u_full (.clk(clk), .reset(rst_full), .vga(bus_full));
  vga_timing_gen #(.CLK_DIV(2)) u_d2 (.clk(clk), .reset(rst_d2), .vga(bus_d2));
  vga_timing_gen #(
    .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (.clk(clk), .reset(rst_small), .vga(bus_small));

  int    n_assert = 0;
  int    n_fail = 0;
  int    k_full = 0, k_d2 = 0, k_small = 0;
  int    cyc = 0;
  int    ft_count = 0, ft_last = 0, ft_prev = 0;
  int    hs_low = 0;
  int    rs_cyc = 0;
  bit    found;

  // Expected outputs k clocks after reset: pixel index = k / d, laid out row-major over the frame
  function automatic exp_t model(input int k, input int d, input int hv, input int hf, input int hs,
                                 input int hb, input int vv, input int vf, input int vs, input int vb);
    exp_t e;
    int   ht, vt, pix, xx, yy;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    pix = k / d;
    xx  = pix % ht;
    yy  = (pix / ht) % vt;
    e.p_tick     = ((k % d) == d - 1);
    e.x          = 10'(xx);
    e.y          = 10'(yy);
    e.hsync      = !(xx >= hv + hf && xx < hv + hf + hs);
    e.vsync      = !(yy >= vv + vf && yy < vv + vf + vs);
    e.video_on   = (xx < hv) && (yy < vv);
    e.frame_tick = e.p_tick && xx == 0 && yy == vv;
    e.rgb        = 12'h000;
    if (e.video_on && k >= d) begin
      case (xx / (hv / 8))
        0: e.rgb = 12'hfff;
        1: e.rgb = 12'hff0;
        2: e.rgb = 12'h0ff;
        3: e.rgb = 12'h0f0;
        4: e.rgb = 12'hf0f;
        5: e.rgb = 12'hf00;
        6: e.rgb = 12'h00f;
        default: e.rgb = 12'h000;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t obs_full();
    exp_t o;
    o = '{bus_full.p_tick, bus_full.x, bus_full.y, bus_full.hsync, bus_full.vsync,
          bus_full.video_on, bus_full.frame_tick, 12'h000};
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = bus_full.rgb;
`endif
    return o;
  endfunction

  function automatic exp_t obs_d2();
    exp_t o;
    o = '{bus_d2.p_tick, bus_d2.x, bus_d2.y, bus_d2.hsync, bus_d2.vsync,
          bus_d2.video_on, bus_d2.frame_tick, 12'h000};
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = bus_d2.rgb;
`endif
    return o;
  endfunction

  function automatic exp_t obs_small();
    exp_t o;
    o = '{bus_small.p_tick, bus_small.x, bus_small.y, bus_small.hsync, bus_small.vsync,
          bus_small.video_on, bus_small.frame_tick, 12'h000};
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = bus_small.rgb;
`endif
    return o;
  endfunction

  task automatic chk(input string tag, input string field, input logic [31:0] ov, input logic [31:0] ev);
    n_assert++;
    assert (ov === ev) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, ov, ev);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t o, input exp_t e);
    chk(tag, "p_tick",     32'(o.p_tick),     32'(e.p_tick));
    chk(tag, "x",          32'(o.x),          32'(e.x));
    chk(tag, "y",          32'(o.y),          32'(e.y));
    chk(tag, "hsync",      32'(o.hsync),      32'(e.hsync));
    chk(tag, "vsync",      32'(o.vsync),      32'(e.vsync));
    chk(tag, "video_on",   32'(o.video_on),   32'(e.video_on));
    chk(tag, "frame_tick", 32'(o.frame_tick), 32'(e.frame_tick));
`ifdef VGA_TEST_PATTERN_EN
    chk(tag, "rgb",        32'(o.rgb),        32'(e.rgb));
`endif
  endtask

  // One clock per iteration: drive resets, advance model clocks on the edge, compare on the falling edge
  task automatic applyStimulus(input int cycles, input bit rf, input bit rd, input bit rs, input bit rand_rs);
    for (int i = 0; i < cycles; i++) begin
      rst_full  = rf;
      rst_d2    = rd;
      rst_small = rand_rs ? ($urandom_range(0, 399) == 0) : rs;
      @(posedge clk);
      k_full  = rst_full  ? 0 : k_full + 1;
      k_d2    = rst_d2    ? 0 : k_d2 + 1;
      k_small = rst_small ? 0 : k_small + 1;
      cyc++;
      @(negedge clk);
      checkOutput("full",  obs_full(),  model(k_full, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      checkOutput("div2",  obs_d2(),    model(k_d2, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      checkOutput("small", obs_small(), model(k_small, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
      if (bus_small.frame_tick) begin
        ft_count++;
        ft_prev = ft_last;
        ft_last = cyc;
      end
      if (!rst_full && bus_full.y == 10'd0 && !bus_full.hsync) hs_low++;
    end
  endtask

  initial begin
    rst_full = 1'b1;
    rst_d2 = 1'b1;
    rst_small = 1'b1;

    $display("[TB] reset hold");
    applyStimulus(5, 1, 1, 1, 0);

    $display("[TB] first line on default timing");
    applyStimulus(3208, 0, 0, 0, 0);
    chk("full", "hsync_low_clocks", 32'(hs_low), 32'(96 * 4));
    chk("full", "y_after_wrap", 32'(bus_full.y), 32'd1);

    $display("[TB] mid-line reset on default timing");
    found = 1'b0;
    for (int i = 0; i < 3200 && !found; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      found = (bus_full.x == 10'd300) && (bus_full.y == 10'd1);
    end
    chk("full", "reach_x300", 32'(found), 32'd1);
    applyStimulus(1, 1, 0, 0, 0);
    chk("full", "x_after_reset", 32'(bus_full.x), 32'd0);
    chk("full", "y_after_reset", 32'(bus_full.y), 32'd0);

    $display("[TB] two frames on small geometry");
    applyStimulus(1, 0, 0, 1, 0);
    rs_cyc = cyc;
    ft_count = 0;
    applyStimulus(2 * FRAME_S, 0, 0, 0, 0);
    chk("small", "frame_ticks", 32'(ft_count), 32'd2);
    chk("small", "frame_period", 32'(ft_last - ft_prev), 32'(FRAME_S));
    chk("small", "first_tick_delay", 32'(ft_prev - rs_cyc), 32'(SVV * SHT * SD + SD - 1));

    $display("[TB] mid-frame reset on small geometry");
    found = 1'b0;
    for (int i = 0; i < FRAME_S && !found; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      found = (bus_small.x == 10'd10) && (bus_small.y == 10'd8);
    end
    chk("small", "reach_mid_frame", 32'(found), 32'd1);
    applyStimulus(1, 0, 0, 1, 0);
    rs_cyc = cyc;
    ft_count = 0;
    applyStimulus(800, 0, 0, 0, 0);
    chk("small", "ticks_after_reset", 32'(ft_count), 32'd1);
    chk("small", "tick_delay_after_reset", 32'(ft_last - rs_cyc), 32'(SVV * SHT * SD + SD - 1));

    $display("[TB] random resets on small geometry");
    applyStimulus(6000, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
